snowbro2_pcm_fetch: RTL and testbench
=====================================

Name: snowbro2_pcm_fetch

Overview:
- Sits directly upstream of the OKI6295 ADPCM decoder's ROM port, between that port and the SDRAM PCM channel.
- Composes the banked PCM byte address, holds a single 32-bit line buffer, and issues SDRAM word requests on a miss.
- Returns bytes with a rom_ok-style valid flag, so the decoder stalls only on real misses.
- Also owns the CPU-written OKI bank register and a flush path used during ROM download.

Parameters:
- AW, 20, byte address width presented to SDRAM (bank bits + 18-bit OKI address).
- BANK_W, 2, width of the OKI bank register; only the low AW-18 bits are used in the address.
- TIMEOUT, 255, cycles to wait for sdram_valid after sdram_ack before re-issuing the request.

Ports:
- CLK96  in  1  system audio clock.
- RESET96_N  in  1  asynchronous active-low reset.
- FLUSH  in  1  high during ROM download: invalidates the line and suppresses requests.
- BANK_EN  in  1  1 = bank bits are prepended to the address; 0 = bank bits forced to 0.
- BANK_WE  in  1  one-cycle strobe that writes BANK_DIN into the bank register.
- BANK_DIN  in  BANK_W  bank value.
- OKI_ADDR  in  18  byte address from the decoder.
- OKI_DATA  out  8  byte at OKI_ADDR.
- OKI_OK  out  1  OKI_DATA is valid for the current OKI_ADDR.
- SDRAM_REQ  out  1  word request, level-held until ack.
- SDRAM_ADDR  out  AW-2  word address, stable while SDRAM_REQ is high.
- SDRAM_ACK  in  1  one-cycle pulse: request accepted.
- SDRAM_VALID  in  1  one-cycle pulse: SDRAM_DATA holds the requested word.
- SDRAM_DATA  in  32  little-endian word; byte 0 is at [7:0].
- RETRIES  out  8  saturating count of timeout re-issues, for debug.

Behaviour:
Reset values:
- bank = 0, tag_valid = 0, tag = 0, line = 0.
- state = IDLE, SDRAM_REQ = 0, SDRAM_ADDR = 0, RETRIES = 0, timer = 0.

Address composition and output mux:
- Full address fa = {BANK_EN ? bank : 0, OKI_ADDR}, truncated to AW bits.
- Word address wa = fa[AW-1:2].
- OKI_OK = tag_valid & (tag == wa) & ~FLUSH. This is combinational, so a hit has zero latency.
- OKI_DATA = line byte selected by fa[1:0]. Combinational; value is don't-care when OKI_OK = 0.

Bank register:
- BANK_WE loads bank on the next edge.
- The tag includes the bank bits, so a bank change does not invalidate the line. It simply misses unless the new word happens to match.

FSM states: IDLE, REQ, WAIT.
- IDLE:
  - If ~FLUSH and ~OKI_OK: latch SDRAM_ADDR <= wa, set SDRAM_REQ = 1, go to REQ.
  - Otherwise stay in IDLE.
- REQ:
  - Hold SDRAM_REQ and SDRAM_ADDR.
  - On SDRAM_ACK: SDRAM_REQ <= 0, timer <= 0, go to WAIT.
- WAIT:
  - On SDRAM_VALID: line <= SDRAM_DATA, tag <= SDRAM_ADDR, tag_valid <= 1, go to IDLE.
  - Otherwise timer increments. When timer == TIMEOUT: RETRIES++ (saturate at 255), SDRAM_REQ <= 1, go to REQ with the same address.
- If SDRAM_ACK and SDRAM_VALID arrive in the same cycle while in REQ, treat it as ack followed immediately by fill: fill the line and go to IDLE.

Latency:
- Miss to OKI_OK = 1 is 1 cycle (IDLE→REQ), plus the SDRAM ack delay, plus the valid delay, plus 1 cycle for the line write.
- Minimum is 3 cycles when ack and valid arrive on consecutive cycles.

Address change mid-fetch:
- The in-flight request completes and fills the line with the old word. It is never abandoned, because SDRAM cannot cancel.
- In the following IDLE cycle the new address misses and a new request is issued.
- OKI_OK stays 0 throughout.

FLUSH:
- tag_valid is cleared every cycle FLUSH is high.
- FLUSH seen in IDLE: no request is issued.
- FLUSH seen in REQ or WAIT: the transaction completes, but the fill does not set tag_valid while FLUSH is high.

Other boundaries:
- Address wrap: fa is truncated to AW bits with no carry into the bank.
- BANK_WE and a fill in the same cycle: both take effect; the tag uses the latched SDRAM_ADDR, not the new bank.
- RESET96_N asserted mid-transaction: all state returns to reset values asynchronously. A later stray SDRAM_VALID arriving in IDLE is ignored.

Test Plan:
1. Reset, BANK_EN=1, bank=0, OKI_ADDR=0x00005 → SDRAM_REQ=1 with SDRAM_ADDR=0x00001. Ack at t+2, valid at t+4 with 0x44332211 → OKI_OK=1, OKI_DATA=0x22 on the next cycle.
2. Same line, OKI_ADDR 0x00004 then 0x00007 → OKI_OK stays 1 with no new SDRAM_REQ; OKI_DATA = 0x11, then 0x44.
3. BANK_WE with BANK_DIN=1, OKI_ADDR=0x00004 → miss with SDRAM_ADDR=0x10001. With BANK_EN=0 the same write gives a hit on the old line.
4. OKI_ADDR changes 0x00100→0x00200 while in WAIT → line fills with word 0x40, OKI_OK stays 0, then a second request for 0x80 is issued. Exactly 2 requests in total.
5. Ack given, valid withheld for TIMEOUT+1 cycles → SDRAM_REQ re-asserts with the same address and RETRIES=1. Valid after the second ack → OKI_OK=1.
6. FLUSH=1 during WAIT, then valid → OKI_OK=0. After FLUSH drops, one new request is issued for the current address. Async RESET96_N pulse in REQ → SDRAM_REQ=0 immediately.

Source files
------------

// File: rtl/snowbro2_pcm_fetch.sv
// snowbro2_pcm_fetch
//   Byte-wide PCM fetch front-end for the OKI6295 ADPCM decoder. It builds the
//   banked byte address, keeps one 32-bit line buffer and fetches a new SDRAM
//   word only on a miss. OKI_OK is combinational, so hits have zero latency.
//   It also holds the CPU-written OKI bank register and a flush path that is
//   used while the ROM is being downloaded.
//
// Ports
//   CLK96, RESET96_N      : audio clock, asynchronous active-low reset
//   FLUSH                 : invalidates the line and blocks new requests
//   BANK_EN               : 1 = bank bits prepended to the address, 0 = bank forced to 0
//   BANK_WE, BANK_DIN     : one-cycle bank register write strobe and value
//   OKI_ADDR              : byte address from the decoder
//   OKI_DATA, OKI_OK      : byte at OKI_ADDR and its valid flag
//   SDRAM_REQ, SDRAM_ADDR : word request (held until ack) and word address
//   SDRAM_ACK, SDRAM_VALID, SDRAM_DATA : request accept pulse, data pulse, word
//   RETRIES               : saturating count of timeout re-issues (debug)

module snowbro2_pcm_fetch #(
  parameter int AW      = 20,
  parameter int BANK_W  = 2,
  parameter int TIMEOUT = 255
) (
  input  logic              CLK96,
  input  logic              RESET96_N,
  input  logic              FLUSH,
  input  logic              BANK_EN,
  input  logic              BANK_WE,
  input  logic [BANK_W-1:0] BANK_DIN,
  input  logic [17:0]       OKI_ADDR,
  output logic [7:0]        OKI_DATA,
  output logic              OKI_OK,
  output logic              SDRAM_REQ,
  output logic [AW-3:0]     SDRAM_ADDR,
  input  logic              SDRAM_ACK,
  input  logic              SDRAM_VALID,
  input  logic [31:0]       SDRAM_DATA,
  output logic [7:0]        RETRIES
);

  localparam int TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT
  } state_t;

  state_t              state, state_nxt;
  logic [BANK_W-1:0]   bank, bank_nxt;
  logic                tag_valid, tag_valid_nxt;
  logic [AW-3:0]       tag, tag_nxt;
  logic [31:0]         line, line_nxt;
  logic [TW-1:0]       timer, timer_nxt;
  logic                req_nxt;
  logic [AW-3:0]       addr_nxt;
  logic [7:0]          retries_nxt;
  logic                fill;

  logic [BANK_W-1:0]   bank_sel;
  logic [AW-1:0]       fa;
  logic [AW-3:0]       wa;

  // The size cast truncates (or zero-extends) to AW bits, so a high OKI
  // address never carries into the bank field.
  assign bank_sel = BANK_EN ? bank : '0;
  assign fa       = AW'({bank_sel, OKI_ADDR});
  assign wa       = fa[AW-1:2];

  // The tag holds the full word address including bank bits, so a bank
  // change only causes a miss; the line does not need to be invalidated.
  assign OKI_OK   = tag_valid & (tag == wa) & ~FLUSH;
  assign OKI_DATA = line[{fa[1:0], 3'b000} +: 8];

  always_ff @(posedge CLK96 or negedge RESET96_N) begin
    if (!RESET96_N) begin
      state      <= IDLE;
      bank       <= '0;
      tag_valid  <= 1'b0;
      tag        <= '0;
      line       <= '0;
      timer      <= '0;
      SDRAM_REQ  <= 1'b0;
      SDRAM_ADDR <= '0;
      RETRIES    <= '0;
    end else begin
      state      <= state_nxt;
      bank       <= bank_nxt;
      tag_valid  <= tag_valid_nxt;
      tag        <= tag_nxt;
      line       <= line_nxt;
      timer      <= timer_nxt;
      SDRAM_REQ  <= req_nxt;
      SDRAM_ADDR <= addr_nxt;
      RETRIES    <= retries_nxt;
    end
  end

  // Once issued, a request always runs to completion because SDRAM has no
  // cancel; an address change is picked up as a fresh miss back in IDLE.
  // Ack and valid in the same REQ cycle are taken as ack then fill.
  always_comb begin
    state_nxt   = state;
    req_nxt     = SDRAM_REQ;
    addr_nxt    = SDRAM_ADDR;
    timer_nxt   = timer;
    retries_nxt = RETRIES;
    fill        = 1'b0;

    case (state)
      IDLE: begin
        if (!FLUSH && !OKI_OK) begin
          addr_nxt  = wa;
          req_nxt   = 1'b1;
          state_nxt = REQ;
        end
      end
      REQ: begin
        if (SDRAM_ACK) begin
          req_nxt   = 1'b0;
          timer_nxt = '0;
          if (SDRAM_VALID) begin
            fill      = 1'b1;
            state_nxt = IDLE;
          end else begin
            state_nxt = WAIT;
          end
        end
      end
      WAIT: begin
        if (SDRAM_VALID) begin
          fill      = 1'b1;
          state_nxt = IDLE;
        end else if (timer == TW'(TIMEOUT)) begin
          if (RETRIES != 8'hFF) begin
            retries_nxt = RETRIES + 8'd1;
          end
          req_nxt   = 1'b1;
          state_nxt = REQ;
        end else begin
          timer_nxt = timer + TW'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // The tag comes from the latched request address, so a bank write in the
  // same cycle as a fill cannot corrupt it. A fill seen under FLUSH still
  // writes the line but leaves it invalid.
  always_comb begin
    line_nxt      = line;
    tag_nxt       = tag;
    tag_valid_nxt = tag_valid;
    bank_nxt      = bank;
    if (fill) begin
      line_nxt      = SDRAM_DATA;
      tag_nxt       = SDRAM_ADDR;
      tag_valid_nxt = 1'b1;
    end
    if (FLUSH) begin
      tag_valid_nxt = 1'b0;
    end
    if (BANK_WE) begin
      bank_nxt = BANK_DIN;
    end
  end

endmodule

// File: tb/tb_snowbro2_pcm_fetch.sv
// tb_snowbro2_pcm_fetch
//   Self-checking bench for snowbro2_pcm_fetch. The bench plays the SDRAM
//   side from a small word model; expected SDRAM word addresses and expected
//   decoder bytes are queued when stimulus is applied and compared when the
//   DUT raises SDRAM_REQ or OKI_OK.

module tb_snowbro2_pcm_fetch;

  localparam int AW      = 20;
  localparam int BANK_W  = 2;
  localparam int TIMEOUT = 255;

  logic              CLK96;
  logic              RESET96_N;
  logic              FLUSH;
  logic              BANK_EN;
  logic              BANK_WE;
  logic [BANK_W-1:0] BANK_DIN;
  logic [17:0]       OKI_ADDR;
  logic [7:0]        OKI_DATA;
  logic              OKI_OK;
  logic              SDRAM_REQ;
  logic [AW-3:0]     SDRAM_ADDR;
  logic              SDRAM_ACK;
  logic              SDRAM_VALID;
  logic [31:0]       SDRAM_DATA;
  logic [7:0]        RETRIES;

  int checkCount = 0;
  int errorCount = 0;
  int reqCount   = 0;
  int reqBefore;
  logic prevReq = 1'b0;

  logic [AW-3:0]     reqQ[$];
  logic [7:0]        dataQ[$];
  logic [AW-3:0]     reqAddr;
  logic [BANK_W-1:0] bankModel = '0;

  snowbro2_pcm_fetch #(
    .AW(AW),
    .BANK_W(BANK_W),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .CLK96(CLK96),
    .RESET96_N(RESET96_N),
    .FLUSH(FLUSH),
    .BANK_EN(BANK_EN),
    .BANK_WE(BANK_WE),
    .BANK_DIN(BANK_DIN),
    .OKI_ADDR(OKI_ADDR),
    .OKI_DATA(OKI_DATA),
    .OKI_OK(OKI_OK),
    .SDRAM_REQ(SDRAM_REQ),
    .SDRAM_ADDR(SDRAM_ADDR),
    .SDRAM_ACK(SDRAM_ACK),
    .SDRAM_VALID(SDRAM_VALID),
    .SDRAM_DATA(SDRAM_DATA),
    .RETRIES(RETRIES)
  );

  initial CLK96 = 1'b0;
  always #5 CLK96 = ~CLK96;

  // SDRAM contents: word 1 is pinned to the value the first scenario expects,
  // every other word is a simple scramble of its address.
  function automatic logic [31:0] memWord(input logic [AW-3:0] wa);
    if (wa == 18'h00001) return 32'h44332211;
    return {~wa[7:0], wa[7:0] + 8'h03, wa[15:8] ^ 8'h5A, wa[7:0] ^ 8'hA5};
  endfunction

  // Every comparison funnels through here.
  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge CLK96);
  endtask

  // Drives a decoder address; when a hit is expected later, the byte the
  // model predicts for this address and the current bank setting is queued.
  task automatic applyStimulus(input logic [17:0] addr, input bit expectHit);
    logic [AW-1:0] fa;
    logic [31:0]   w;
    OKI_ADDR = addr;
    fa = AW'({(BANK_EN ? bankModel : {BANK_W{1'b0}}), addr});
    w  = memWord(fa[AW-1:2]);
    if (expectHit) dataQ.push_back(w[{fa[1:0], 3'b000} +: 8]);
  endtask

  task automatic waitReq(input string tag, input int budget);
    int n = 0;
    while (!SDRAM_REQ && n < budget) begin
      tick(1);
      n++;
    end
    if (!SDRAM_REQ) checkOutput({tag, "_req_timeout"}, 0, 1);
    reqAddr = SDRAM_ADDR;
  endtask

  task automatic pulseAck();
    SDRAM_ACK = 1'b1;
    tick(1);
    SDRAM_ACK = 1'b0;
  endtask

  task automatic pulseValid(input logic [AW-3:0] wa);
    SDRAM_VALID = 1'b1;
    SDRAM_DATA  = memWord(wa);
    tick(1);
    SDRAM_VALID = 1'b0;
    SDRAM_DATA  = 32'hDEADBEEF;
  endtask

  task automatic waitHit(input string tag, input int budget);
    int n = 0;
    logic [7:0] exp;
    while (!OKI_OK && n < budget) begin
      tick(1);
      n++;
    end
    if (dataQ.size() == 0) begin
      checkOutput({tag, "_no_expected"}, 1, 0);
      return;
    end
    exp = dataQ.pop_front();
    checkOutput({tag, "_ok"}, OKI_OK, 1);
    checkOutput({tag, "_data"}, OKI_DATA, exp);
  endtask

  // Each rising edge of SDRAM_REQ (including timeout re-issues) must match
  // the next queued word address.
  always @(negedge CLK96) begin
    if (SDRAM_REQ && !prevReq) begin
      reqCount++;
      if (reqQ.size() == 0) checkOutput("unexpected_req", SDRAM_ADDR, 32'hFFFFFFFF);
      else checkOutput("req_addr", SDRAM_ADDR, reqQ.pop_front());
    end
    prevReq = SDRAM_REQ;
  end

  initial begin
    RESET96_N   = 1'b0;
    FLUSH       = 1'b0;
    BANK_EN     = 1'b1;
    BANK_WE     = 1'b0;
    BANK_DIN    = '0;
    OKI_ADDR    = '0;
    SDRAM_ACK   = 1'b0;
    SDRAM_VALID = 1'b0;
    SDRAM_DATA  = '0;
    tick(2);

    // Reset state
    checkOutput("rst_req", SDRAM_REQ, 0);
    checkOutput("rst_addr", SDRAM_ADDR, 0);
    checkOutput("rst_retries", RETRIES, 0);
    checkOutput("rst_ok", OKI_OK, 0);

    // 1: first miss, ack at t+2, valid at t+4
    applyStimulus(18'h00005, 1);
    reqQ.push_back(18'h00001);
    RESET96_N = 1'b1;
    tick(1);
    checkOutput("t1_req_latency", SDRAM_REQ, 1);
    waitReq("t1", 4);
    tick(1);
    pulseAck();
    tick(1);
    checkOutput("t1_ok_before_fill", OKI_OK, 0);
    pulseValid(reqAddr);
    checkOutput("t1_ok_after_fill", OKI_OK, 1);
    waitHit("t1", 0);

    // 2: other bytes of the same line hit with no new request
    reqBefore = reqCount;
    applyStimulus(18'h00004, 1);
    #1 waitHit("t2_b0", 0);
    tick(1);
    applyStimulus(18'h00007, 1);
    #1 waitHit("t2_b3", 0);
    tick(2);
    checkOutput("t2_no_req", reqCount - reqBefore, 0);

    // 3: bank write ignored while BANK_EN=0, then a miss once enabled
    BANK_EN  = 1'b0;
    BANK_WE  = 1'b1;
    BANK_DIN = 2'd1;
    bankModel = 2'd1;
    applyStimulus(18'h00004, 1);
    tick(1);
    BANK_WE = 1'b0;
    waitHit("t3_bank_off", 0);
    tick(1);
    checkOutput("t3_still_hit", OKI_OK, 1);
    BANK_EN = 1'b1;
    applyStimulus(18'h00004, 1);
    reqQ.push_back(18'h10001);
    #1 checkOutput("t3_bank_miss", OKI_OK, 0);
    tick(1);
    waitReq("t3", 4);
    pulseAck();
    pulseValid(reqAddr);
    waitHit("t3", 2);

    // 4: address change while in WAIT, old word still fills
    BANK_EN = 1'b0;
    reqBefore = reqCount;
    applyStimulus(18'h00100, 0);
    reqQ.push_back(18'h00040);
    tick(1);
    waitReq("t4a", 4);
    pulseAck();
    applyStimulus(18'h00200, 1);
    reqQ.push_back(18'h00080);
    tick(1);
    checkOutput("t4_ok_wait", OKI_OK, 0);
    pulseValid(reqAddr);
    checkOutput("t4_ok_after_old_fill", OKI_OK, 0);
    tick(1);
    checkOutput("t4_second_req", SDRAM_REQ, 1);
    waitReq("t4b", 4);
    checkOutput("t4_second_addr", reqAddr, 18'h00080);
    pulseAck();
    pulseValid(reqAddr);
    waitHit("t4", 2);
    tick(1);
    checkOutput("t4_req_total", reqCount - reqBefore, 2);

    // 5: valid withheld past the timeout, request re-issued
    applyStimulus(18'h00300, 1);
    reqQ.push_back(18'h000C0);
    reqQ.push_back(18'h000C0);
    tick(1);
    waitReq("t5a", 4);
    pulseAck();
    checkOutput("t5_req_dropped", SDRAM_REQ, 0);
    tick(TIMEOUT);
    checkOutput("t5_req_before_timeout", SDRAM_REQ, 0);
    tick(1);
    checkOutput("t5_req_reissued", SDRAM_REQ, 1);
    checkOutput("t5_retry_addr", SDRAM_ADDR, 18'h000C0);
    checkOutput("t5_retries", RETRIES, 1);
    pulseAck();
    pulseValid(18'h000C0);
    waitHit("t5", 2);

    // 6a: FLUSH in IDLE blocks requests; FLUSH during WAIT blocks validity
    FLUSH = 1'b1;
    applyStimulus(18'h00400, 0);
    reqBefore = reqCount;
    tick(3);
    checkOutput("t6_flush_idle_noreq", SDRAM_REQ, 0);
    reqQ.push_back(18'h00100);
    FLUSH = 1'b0;
    tick(1);
    waitReq("t6a", 4);
    pulseAck();
    FLUSH = 1'b1;
    tick(1);
    pulseValid(reqAddr);
    checkOutput("t6_ok_under_flush", OKI_OK, 0);
    applyStimulus(18'h00400, 1);
    reqQ.push_back(18'h00100);
    FLUSH = 1'b0;
    #1 checkOutput("t6_fill_not_valid", OKI_OK, 0);
    tick(1);
    waitReq("t6b", 4);
    pulseAck();
    pulseValid(reqAddr);
    waitHit("t6", 2);
    tick(1);
    checkOutput("t6_req_total", reqCount - reqBefore, 2);

    // 6b: asynchronous reset in REQ, then a stray valid in IDLE
    applyStimulus(18'h00500, 0);
    reqQ.push_back(18'h00140);
    tick(1);
    waitReq("t6c", 4);
    #1 RESET96_N = 1'b0;
    #1;
    checkOutput("t6_async_req", SDRAM_REQ, 0);
    checkOutput("t6_async_addr", SDRAM_ADDR, 0);
    checkOutput("t6_async_retries", RETRIES, 0);
    bankModel = '0;
    applyStimulus(18'h00000, 1);
    reqQ.push_back(18'h00000);
    tick(1);
    RESET96_N   = 1'b1;
    SDRAM_VALID = 1'b1;
    SDRAM_DATA  = memWord(18'h00000);
    tick(1);
    SDRAM_VALID = 1'b0;
    checkOutput("t6_stray_valid_ignored", OKI_OK, 0);
    waitReq("t6d", 4);
    pulseAck();
    pulseValid(reqAddr);
    waitHit("t6_after_reset", 2);

    tick(2);
    checkOutput("req_queue_drained", reqQ.size(), 0);
    checkOutput("data_queue_drained", dataQ.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
